mio_responder: RTL and testbench

Memory/IO responder on the far side of the multi-cycle CPU's memory interface. It accepts level-held `MemRead`/`MemWrite` requests, inserts a configurable number of wait states, and returns read data with a one-cycle `MIO_ready` pulse. It serves a word-addressed instruction/data RAM plus three memory-mapped peripherals (LED register, switch input, cycle counter). It sits between the CPU datapath's address/write-data buses and the board I/O.

---
 rtl/mio_pkg.sv | 22 ++
 rtl/mio_if.sv | 22 ++
 rtl/mio_ram.sv | 23 ++
 rtl/mio_responder.sv | 171 +++++++++++++++++
 tb/tb_mio_responder.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO responder.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mio_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mio_state_t;

  // Wait-state counter width; covers WAIT_CYCLES 0..15
  localparam int MIO_WCNT_W = 4;

  // Top nibble selecting the memory-mapped peripheral region
  localparam logic [3:0]  MIO_IO_REGION = 4'hF;
  localparam logic [31:0] MIO_LED_ADDR  = 32'hF000_0000;
  localparam logic [31:0] MIO_SW_ADDR   = 32'hF000_0004;
  localparam logic [31:0] MIO_CNT_ADDR  = 32'hF000_0008;

endpackage

// File: rtl/mio_if.sv
// CPU-side memory bus between the multi-cycle datapath and the responder.
// Latency: n/a (wiring only).
// Backpressure: requests are level-held by the CPU until MIO_ready pulses.
interface mio_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        MIO_ready;
  logic        busy;

  modport master (
    output MemRead, MemWrite, addr, wdata,
    input  rdata, MIO_ready, busy
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata,
    output rdata, MIO_ready, busy
  );
endinterface

// File: rtl/mio_ram.sv
// Word-addressed single-port RAM, read-before-write on a shared index.
// Latency: registered read, data one cycle after the index is presented.
// Backpressure: none; accepts a read and optional write every cycle.
module mio_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [WORDS];

  // Write when enabled; always register the addressed word for reading
  always_ff @(posedge clk) begin
    if (we) r_mem[idx] <= wdata;
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/mio_responder.sv
// Memory/IO responder: RAM plus LED, switch and cycle-counter registers.
// Latency: MIO_ready in cycle WAIT_CYCLES+1 after the request is accepted.
// Backpressure: requests ignored while busy; one access per WAIT_CYCLES+2 cycles.
module mio_responder
  import mio_pkg::*;
#(
  parameter int RAM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int LED_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  mio_if.slave             bus,
  input  logic [15:0]      sw,
  output logic [LED_W-1:0] led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [MIO_WCNT_W-1:0] WAIT_INIT = MIO_WCNT_W'(WAIT_CYCLES);

  mio_state_t            r_state, w_next;
  logic [MIO_WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic [31:0]           r_addr, r_wdata, r_rdata, r_cnt;
  logic                  r_is_wr, r_rd_ram;
  logic [LED_W-1:0]      r_led;
  logic [15:0]           r_sw_meta, r_sw_sync;

  logic        w_req, w_accept, w_fire;
  logic [31:0] w_acc_addr, w_acc_wdata, w_prd, w_ram_q;
  logic        w_acc_wr, w_io, w_hit_ram, w_hit_led, w_hit_sw, w_hit_cnt;
  logic        w_ram_we, w_unused;
  logic [29:0] w_word;

  assign w_req = bus.MemRead | bus.MemWrite;

  // In IDLE the live bus is the access (zero-wait case); otherwise the latched copy
  assign w_acc_addr  = (r_state == IDLE) ? bus.addr     : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? bus.wdata    : r_wdata;
  assign w_acc_wr    = (r_state == IDLE) ? bus.MemWrite : r_is_wr;

  assign w_word    = w_acc_addr[31:2];
  assign w_unused  = ^w_acc_addr[1:0];
  assign w_io      = (w_acc_addr[31:28] == MIO_IO_REGION);
  assign w_hit_ram = !w_io && ({2'b00, w_word} < 32'(RAM_WORDS));
  assign w_hit_led = ({w_word, 2'b00} == MIO_LED_ADDR);
  assign w_hit_sw  = ({w_word, 2'b00} == MIO_SW_ADDR);
  assign w_hit_cnt = ({w_word, 2'b00} == MIO_CNT_ADDR);

  // Next-state and wait-counter logic; w_fire marks the edge that enters RESP
  always_comb begin
    w_next     = r_state;
    w_wcnt_nxt = r_wcnt;
    w_accept   = 1'b0;
    w_fire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept   = 1'b1;
          w_wcnt_nxt = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            w_next = RESP;
            w_fire = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        w_wcnt_nxt = r_wcnt - 1'b1;
        if (r_wcnt <= 1) begin
          w_next = RESP;
          w_fire = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign bus.MIO_ready = (r_state == RESP);
  assign bus.busy      = (r_state != IDLE);

  // State and wait-counter registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  // Latch the request so later bus changes cannot affect it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
      r_is_wr <= bus.MemWrite;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // LED register write at the commit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_led <= '0;
    else if (w_fire && w_acc_wr && w_hit_led) r_led <= w_acc_wdata[LED_W-1:0];
  end

  assign led = r_led;

  // Free-running cycle counter; a write clears it and skips that increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_cnt <= '0;
    else if (w_fire && w_acc_wr && w_hit_cnt) r_cnt <= '0;
    else                                    r_cnt <= r_cnt + 32'd1;
  end

  // Peripheral read mux; unmapped reads return zero
  always_comb begin
    w_prd = '0;
    if (w_hit_led)      w_prd[LED_W-1:0] = r_led;
    else if (w_hit_sw)  w_prd = {16'h0000, r_sw_sync};
    else if (w_hit_cnt) w_prd = r_cnt;
  end

  // Read capture: peripherals at the commit edge; RAM word is held once RESP ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata  <= '0;
      r_rd_ram <= 1'b0;
    end else if (w_fire && !w_acc_wr) begin
      r_rd_ram <= w_hit_ram;
      r_rdata  <= w_hit_ram ? r_rdata : w_prd;
    end else if (r_state == RESP && r_rd_ram) begin
      r_rdata  <= w_ram_q;
      r_rd_ram <= 1'b0;
    end
  end

  // During a RAM read response the RAM's registered output is the data
  assign bus.rdata = (r_state == RESP && r_rd_ram) ? w_ram_q : r_rdata;

  assign w_ram_we = w_fire && w_acc_wr && w_hit_ram && !reset;

  mio_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .idx   (w_word[AW-1:0]),
    .wdata (w_acc_wdata),
    .rdata (w_ram_q)
  );

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder with a queue-based response scoreboard.
// Latency: expects MIO_ready WAIT_CYCLES+1 cycles after each request.
// Backpressure: requests are held until MIO_ready, as the CPU does.
module tb_mio_responder;

  localparam int W = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw;
  logic [15:0] led;

  mio_if bus();

  mio_responder #(
    .RAM_WORDS   (1024),
    .WAIT_CYCLES (W),
    .LED_W       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .led   (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   after_resp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pops one expectation and checks timing and data
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.MIO_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("ready_cycle", cyc, e.cyc);
        if (e.chk) check("rdata", bus.rdata, e.exp);
      end
    end
  end

  // Issue one held request and wait for its response
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit chk, input logic [31:0] exp);
    exp_t e;
    bit   got;
    int   issue;
    bus.MemWrite = wr;
    bus.MemRead  = rd;
    bus.addr     = a;
    bus.wdata    = d;
    issue  = after_resp ? cyc + 1 : cyc;
    e.chk  = chk;
    e.exp  = exp;
    e.cyc  = issue + W + 1;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.MIO_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: no MIO_ready for addr %h within 20 cycles", a);
    end
    after_resp = got;
  endtask

  task automatic idle(input int n);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    repeat (n) @(negedge clk);
    if (n > 0) after_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    sw           = 16'hBEEF;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ready", {31'b0, bus.MIO_ready}, 32'h0);
    check("rst_busy",  {31'b0, bus.busy},      32'h0);
    check("rst_rdata", bus.rdata,              32'h0);
    check("rst_led",   {16'h0, led},           32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Read after write
    access(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0);
    idle(1);
    access(0, 1, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF);
    idle(1);

    // Preload words 0..2, then back-to-back reads with MemRead held
    access(1, 0, 32'h0000_0000, 32'd1, 1, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_0004, 32'd2, 1, 32'hDEAD_BEEF);
    access(1, 0, 32'h0000_0008, 32'd3, 1, 32'hDEAD_BEEF);
    idle(1);
    access(0, 1, 32'h0000_0000, 32'h0, 1, 32'd1);
    access(0, 1, 32'h0000_0004, 32'h0, 1, 32'd2);
    access(0, 1, 32'h0000_0008, 32'h0, 1, 32'd3);
    idle(1);

    // Peripherals
    access(1, 0, 32'hF000_0000, 32'h1234_5A5A, 1, 32'd3);
    idle(1);
    check("led_write", {16'h0, led}, 32'h0000_5A5A);
    access(0, 1, 32'hF000_0004, 32'h0, 1, 32'h0000_BEEF);
    access(1, 0, 32'hF000_0004, 32'h0000_FFFF, 1, 32'h0000_BEEF);
    access(0, 1, 32'hF000_0004, 32'h0, 1, 32'h0000_BEEF);
    access(0, 1, 32'hF000_0000, 32'h0, 1, 32'h0000_5A5A);
    idle(1);
    check("led_hold", {16'h0, led}, 32'h0000_5A5A);

    // Counter clear then immediate read
    access(1, 0, 32'hF000_0008, 32'h0000_ABCD, 1, 32'h0000_5A5A);
    access(0, 1, 32'hF000_0008, 32'h0, 1, 32'(W + 1));
    idle(1);

    // Counter wrap
    force dut.r_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_cnt;
    @(negedge clk);
    check("cnt_wrap", dut.r_cnt, 32'h0);
    access(0, 1, 32'hF000_0008, 32'h0, 1, 32'd2);
    idle(1);

    // Unmapped read, unmapped write must not alias RAM
    access(0, 1, 32'h0001_0000, 32'h0, 1, 32'h0);
    access(1, 0, 32'h0000_1000, 32'h99, 1, 32'h0);
    access(0, 1, 32'h0000_0000, 32'h0, 1, 32'd1);
    // Both strobes high: write wins
    access(1, 1, 32'h0000_0020, 32'd7, 1, 32'd1);
    access(0, 1, 32'h0000_0020, 32'h0, 1, 32'd7);
    access(1, 0, 32'h0000_0040, 32'h11, 1, 32'd7);
    idle(1);

    // Reset in the WAIT cycle of a write
    bus.MemWrite = 1'b1;
    bus.addr     = 32'h0000_0040;
    bus.wdata    = 32'h55;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'b0, bus.MIO_ready}, 32'h0);
    check("mid_rst_busy",  {31'b0, bus.busy},      32'h0);
    check("mid_rst_rdata", bus.rdata,              32'h0);
    check("mid_rst_led",   {16'h0, led},           32'h0);
    bus.MemWrite = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    after_resp = 1'b0;
    access(0, 1, 32'h0000_0040, 32'h0, 1, 32'h11);
    idle(3);

    check("sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
